// File: rtl/microwave_timer.sv
// microwave_timer: oven controller with prescaled cook countdown, door pause/resume,
// add-time while cooking and a timed completion beep.
module microwave_timer #(
    parameter int TIME_W      = 8,
    parameter int TICK_DIV    = 10,
    parameter int ADD_TIME    = 30,
    parameter int BEEP_CYCLES = 3
) (
    input  logic              clk,
    input  logic              sys_reset,
    input  logic              reset,
    input  logic              closeDoor,
    input  logic              startOven,
    input  logic [TIME_W-1:0] cookTime,
    output logic [3:0]        States,
    output logic [TIME_W-1:0] remaining,
    output logic              heat,
    output logic              light,
    output logic              cookDone
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BEEP_CYCLES) + 1;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        OPEN     = 4'd1,
        COOK     = 4'd2,
        PAUSE    = 4'd3,
        COMPLETE = 4'd4
    } state_t;

    state_t            state, state_n;
    logic [TIME_W-1:0] rem_n;
    logic [PW-1:0]     pre, pre_n;
    logic [BW-1:0]     beep, beep_n;
    logic              start_q, start_edge, tick;
    logic [TIME_W:0]   sum;

    assign start_edge = startOven & ~start_q;
    assign tick       = (state == COOK) && (pre == PW'(TICK_DIV - 1));
    // add-time absorbs a coincident tick; bit TIME_W flags saturation
    assign sum        = {1'b0, remaining} + (TIME_W+1)'(ADD_TIME) - {{TIME_W{1'b0}}, tick};
    assign States     = state;

    always_comb begin
        state_n = state;
        rem_n   = remaining;
        pre_n   = pre;
        beep_n  = '0;
        if (reset) begin
            state_n = IDLE;
            rem_n   = '0;
            pre_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!closeDoor) state_n = OPEN;
                    else if (start_edge && cookTime != '0) begin
                        state_n = COOK;
                        rem_n   = cookTime;
                        pre_n   = '0;
                    end
                end
                OPEN: state_n = closeDoor ? IDLE : OPEN;
                COOK: begin
                    if (!closeDoor) state_n = PAUSE;
                    else begin
                        pre_n = tick ? '0 : pre + 1'b1;
                        if (start_edge) rem_n = sum[TIME_W] ? '1 : sum[TIME_W-1:0];
                        else if (tick) begin
                            rem_n   = remaining - 1'b1;
                            state_n = (remaining == TIME_W'(1)) ? COMPLETE : COOK;
                        end
                    end
                end
                PAUSE: state_n = (closeDoor && start_edge) ? COOK : PAUSE;
                COMPLETE: begin
                    if (!closeDoor) state_n = OPEN;
                    else if (beep == BW'(BEEP_CYCLES - 1)) state_n = IDLE;
                    else beep_n = beep + 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state     <= IDLE;
            remaining <= '0;
            pre       <= '0;
            beep      <= '0;
            start_q   <= 1'b0;
            heat      <= 1'b0;
            light     <= 1'b0;
            cookDone  <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= rem_n;
            pre       <= pre_n;
            beep      <= beep_n;
            start_q   <= startOven;
            heat      <= state_n == COOK;
            light     <= state_n inside {OPEN, COOK, PAUSE};
            cookDone  <= state_n == COMPLETE;
        end
    end
endmodule

// File: tb/tb_microwave_timer.sv
// tb_microwave_timer: directed checks of cooking, pause/resume, add-time, cancel and reset.
module tb_microwave_timer;
    logic       clk = 1'b0;
    logic       sys_reset, reset, closeDoor, startOven;
    logic [7:0] cookTime;
    logic [3:0] States;
    logic [7:0] remaining;
    logic       heat, light, cookDone;
    int         total = 0;
    int         bad = 0;

    microwave_timer #(.TIME_W(8), .TICK_DIV(4), .ADD_TIME(30), .BEEP_CYCLES(3)) dut (
        .clk(clk), .sys_reset(sys_reset), .reset(reset), .closeDoor(closeDoor),
        .startOven(startOven), .cookTime(cookTime), .States(States),
        .remaining(remaining), .heat(heat), .light(light), .cookDone(cookDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int st, input int rem, input int h, input int l, input int d);
        chk({tag, ".st"}, 32'(States), 32'(st));
        chk({tag, ".rem"}, 32'(remaining), 32'(rem));
        chk({tag, ".heat"}, 32'(heat), 32'(h));
        chk({tag, ".light"}, 32'(light), 32'(l));
        chk({tag, ".done"}, 32'(cookDone), 32'(d));
    endtask

    initial begin
        sys_reset = 1'b0; reset = 1'b0; closeDoor = 1'b1; startOven = 1'b0; cookTime = 8'd0;
        #3 chk_out("por", 0, 0, 0, 0, 0);
        step(2);
        sys_reset = 1'b1;
        step(1);
        chk_out("idle", 0, 0, 0, 0, 0);

        cookTime = 8'd3; startOven = 1'b1;
        step(1);
        chk_out("cook_entry", 2, 3, 1, 1, 0);
        startOven = 1'b0;
        step(3);
        chk("cook_pre3", 32'(remaining), 32'd3);
        step(1);
        chk("cook_p4", 32'(remaining), 32'd2);
        step(4);
        chk("cook_p8", 32'(remaining), 32'd1);
        step(4);
        chk_out("complete_p12", 4, 0, 0, 0, 1);
        step(1);
        chk("beep2", 32'(cookDone), 32'd1);
        step(1);
        chk("beep3", 32'(cookDone), 32'd1);
        step(1);
        chk_out("after_beep", 0, 0, 0, 0, 0);

        cookTime = 8'd5; startOven = 1'b1;
        step(1);
        startOven = 1'b0;
        step(13);
        chk("pr_rem2", 32'(remaining), 32'd2);
        closeDoor = 1'b0;
        step(1);
        chk_out("pause", 3, 2, 0, 1, 0);
        step(3);
        chk_out("pause_hold", 3, 2, 0, 1, 0);
        closeDoor = 1'b1;
        step(1);
        chk("pause_noedge", 32'(States), 32'd3);
        startOven = 1'b1;
        step(1);
        chk_out("resume", 2, 2, 1, 1, 0);
        startOven = 1'b0;
        step(6);
        chk_out("resume_p6", 2, 1, 1, 1, 0);
        step(1);
        chk_out("resume_p7", 4, 0, 0, 0, 1);
        step(3);
        chk("resume_idle", 32'(States), 32'd0);

        cookTime = 8'd240; startOven = 1'b1;
        step(1);
        startOven = 1'b0;
        step(1);
        startOven = 1'b1;
        step(1);
        chk_out("add_sat", 2, 255, 1, 1, 0);
        startOven = 1'b0; reset = 1'b1;
        step(1);
        chk_out("cancel_cook", 0, 0, 0, 0, 0);
        reset = 1'b0;

        cookTime = 8'd10; startOven = 1'b1;
        step(1);
        startOven = 1'b0;
        step(3);
        startOven = 1'b1;
        step(1);
        chk_out("add_tick", 2, 39, 1, 1, 0);
        startOven = 1'b0; closeDoor = 1'b0;
        step(1);
        chk_out("pause2", 3, 39, 0, 1, 0);
        reset = 1'b1;
        step(1);
        chk_out("cancel_pause", 0, 0, 0, 0, 0);
        reset = 1'b0; closeDoor = 1'b1;
        cookTime = 8'd0; startOven = 1'b1;
        step(1);
        chk_out("zero_time", 0, 0, 0, 0, 0);
        startOven = 1'b0;
        step(1);

        cookTime = 8'd2; closeDoor = 1'b0;
        step(1);
        chk_out("open", 1, 0, 0, 1, 0);
        startOven = 1'b1;
        step(1);
        chk("stale_open", 32'(States), 32'd1);
        closeDoor = 1'b1;
        step(1);
        chk_out("stale_close", 0, 0, 0, 0, 0);
        step(2);
        chk_out("stale_held", 0, 0, 0, 0, 0);
        startOven = 1'b0;
        step(1);
        startOven = 1'b1;
        step(1);
        chk_out("fresh_press", 2, 2, 1, 1, 0);
        startOven = 1'b0;

        step(1);
        #2 sys_reset = 1'b0;
        #1 chk_out("async_rst", 0, 0, 0, 0, 0);
        cookTime = 8'd4; startOven = 1'b1;
        step(1);
        chk_out("rst_hold", 0, 0, 0, 0, 0);
        sys_reset = 1'b1;
        step(1);
        chk_out("held_start", 2, 4, 1, 1, 0);
        step(2);
        chk("held_single_edge", 32'(remaining), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
